// File: rtl/img_pkg.sv
// img_pkg: pixel/window types and read-side FSM states shared by window_ctrl and line_buffer
package img_pkg;
   localparam int PIX_W = 8;
   localparam int WIN_W = 9 * PIX_W;
   typedef logic [PIX_W-1:0] pixel_t;
   typedef logic [WIN_W-1:0] window_t;
   typedef enum logic [1:0] {IDLE, STREAM, LINE_DONE} win_state_t;
endpackage

// File: rtl/line_buffer.sv
// line_buffer: one image row of pixel storage, single write port, combinational 3-pixel read tap
module line_buffer
   import img_pkg::*;
#(
   parameter int IMG_WIDTH = 512
)(
   input  logic                         i_clk,
   input  logic                         i_we,
   input  logic [$clog2(IMG_WIDTH)-1:0] i_waddr,
   input  pixel_t                       i_wdata,
   input  logic [$clog2(IMG_WIDTH)-1:0] i_raddr,
   output logic [3*PIX_W-1:0]           o_rdata
);
   localparam int CW = $clog2(IMG_WIDTH);
   pixel_t mem_q [IMG_WIDTH];
   // Store one pixel per accepted upstream beat aimed at this row
   always_ff @(posedge i_clk)
      if (i_we) mem_q[i_waddr] <= i_wdata;
   // Byte c of the tap is column i_raddr+c
   always_comb begin
      o_rdata = '0;
      for (int c = 0; c < 3; c++) o_rdata[PIX_W*c +: PIX_W] = mem_q[i_raddr + CW'(c)];
   end
endmodule

// File: rtl/window_ctrl.sv
// window_ctrl: 4-row line-buffer ring feeding 3x3 windows to the convolution; WINDOW_CTRL_STATS_EN builds the o_win_cnt counter
module window_ctrl
   import img_pkg::*;
#(
   parameter int IMG_WIDTH = 512,
   parameter int NUM_BUF   = 4
)(
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_valid,
   input  pixel_t      i_data,
   output logic        o_ready,
   input  logic        i_ready,
   output window_t     o_data,
   output logic        o_valid,
   output logic        o_intr,
   output logic [31:0] o_win_cnt
);
   localparam int CW = $clog2(IMG_WIDTH);
   localparam int BW = $clog2(NUM_BUF);
   localparam int FW = BW + 1;
   localparam logic [CW-1:0] LAST_WR = CW'(IMG_WIDTH - 1);
   localparam logic [CW-1:0] DRAIN   = CW'(IMG_WIDTH - 2);
   localparam logic [FW-1:0] FULL    = FW'(NUM_BUF);
   localparam logic [FW-1:0] ROWS    = FW'(3);

   win_state_t        state_q, state_d;
   logic [CW-1:0]     wr_col_q, wr_col_d, rd_col_q, rd_col_d;
   logic [BW-1:0]     wr_buf_q, wr_buf_d, rd_buf_q, rd_buf_d;
   logic [FW-1:0]     fill_q, fill_d;
   logic              valid_q, valid_d;
   window_t           data_q, data_d, win;
   logic [3*PIX_W-1:0] rows [NUM_BUF];
   logic              acc, row_done, ld, load;

   assign o_ready  = fill_q != FULL;
   assign acc      = i_valid && o_ready;
   assign row_done = acc && wr_col_q == LAST_WR;
   assign ld       = state_q == LINE_DONE;
   assign load     = !valid_q || i_ready;
   assign o_valid  = valid_q;
   assign o_data   = data_q;
   assign o_intr   = ld;

   for (genvar b = 0; b < NUM_BUF; b++) begin : g_buf
      line_buffer #(.IMG_WIDTH(IMG_WIDTH)) u_buf (
         .i_clk  (i_clk),
         .i_we   (acc && wr_buf_q == BW'(b)),
         .i_waddr(wr_col_q),
         .i_wdata(i_data),
         .i_raddr(rd_col_q),
         .o_rdata(rows[b])
      );
   end

   // Stack the three resident rows, oldest first, into one packed window
   always_comb begin
      win = '0;
      for (int r = 0; r < 3; r++) win[3*PIX_W*r +: 3*PIX_W] = rows[rd_buf_q + BW'(r)];
   end

   // Write pointer advance and ring occupancy; a row landing while one is freed leaves fill unchanged
   always_comb begin
      wr_col_d = acc ? (row_done ? '0 : wr_col_q + 1'b1) : wr_col_q;
      wr_buf_d = wr_buf_q + BW'(row_done);
      fill_d   = fill_q + FW'(row_done) - FW'(ld);
   end

   // Read scheduler: load windows into the output register, free the oldest row once its last window leaves
   always_comb begin
      state_d  = state_q;
      rd_col_d = rd_col_q;
      rd_buf_d = rd_buf_q;
      valid_d  = valid_q && !i_ready;
      data_d   = data_q;
      case (state_q)
         IDLE: state_d = fill_q >= ROWS ? STREAM : IDLE;
         STREAM:
            if (load) begin
               if (rd_col_q == DRAIN) state_d = LINE_DONE;
               else begin
                  valid_d  = 1'b1;
                  data_d   = win;
                  rd_col_d = rd_col_q + 1'b1;
               end
            end
         LINE_DONE: begin
            rd_buf_d = rd_buf_q + 1'b1;
            rd_col_d = '0;
            state_d  = fill_d >= ROWS ? STREAM : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; async reset drops partial rows and any pending window at once
   always_ff @(posedge i_clk or negedge i_reset_n)
      if (!i_reset_n) begin
         state_q  <= IDLE;
         wr_col_q <= '0;
         rd_col_q <= '0;
         wr_buf_q <= '0;
         rd_buf_q <= '0;
         fill_q   <= '0;
         valid_q  <= 1'b0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         wr_col_q <= wr_col_d;
         rd_col_q <= rd_col_d;
         wr_buf_q <= wr_buf_d;
         rd_buf_q <= rd_buf_d;
         fill_q   <= fill_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
      end

`ifdef WINDOW_CTRL_STATS_EN
   logic [31:0] win_cnt_q, win_cnt_d;
   // Free-running count of windows handed to the convolution
   always_comb win_cnt_d = win_cnt_q + 32'(valid_q && i_ready);
   // Counter register
   always_ff @(posedge i_clk or negedge i_reset_n)
      if (!i_reset_n) win_cnt_q <= '0;
      else win_cnt_q <= win_cnt_d;
   assign o_win_cnt = win_cnt_q;
`else
   assign o_win_cnt = 32'd0;
`endif
endmodule
